tick_sched: RTL and testbench
=============================

Name: tick_sched

Overview:
- Controller and scheduler for the design's clock-slowing resource.
- Replaces the free-running ripple divider with a programmable, start/stop-controlled clock-enable generator.
- Accepts divide ratios over a valid/ready config handshake and applies them glitch-free only at period boundaries.
- Emits a single-cycle `tick` enable plus a square-wave `phase` in the main `clock` domain, used by ALU sequencing and display-scan logic; no derived clocks.

Parameters:
- CNT_W, 17, width of divide ratio and down-counter.
- DEFAULT_DIV, 100000, ratio loaded at reset; must be >= 2 and < 2**CNT_W.

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- cfg_valid  input  1  new divide ratio offered.
- cfg_ready  output  1  config slot free; transfer when cfg_valid && cfg_ready at a rising edge.
- cfg_div  input  CNT_W  requested ratio in clock cycles per tick.
- start  input  1  level-sampled; begin continuous ticking.
- stop  input  1  level-sampled; halt ticking.
- single  input  1  level-sampled; emit exactly one tick, then return to idle.
- tick  output  1  one-cycle enable pulse, once per period.
- phase  output  1  square wave: high for the last floor(div/2) cycles of each period.
- busy  output  1  state != IDLE.
- tick_cnt  output  8  ticks since last start; present only with TICK_SCHED_CNT_EN.

Behaviour:
- Reset values (reset low, async):
  - state = IDLE, div_reg = DEFAULT_DIV, cnt = 0, pending_valid = 0.
  - Outputs: tick = 0, phase = 0, busy = 0, cfg_ready = 1, tick_cnt = 0.
  - Reset is honoured mid-period and mid-handshake; the pending config is discarded.
- States: IDLE, RUN, ONESHOT.
- Clamp: any accepted cfg_div < 2 is stored as 2.
  - div_reg is never below 2.
- Config handshake:
  - cfg_ready = !pending_valid.
  - Accepted in IDLE: div_reg <= cfg_div next cycle.
  - Accepted in RUN/ONESHOT: value goes to pending, pending_valid <= 1.
  - Pending is applied at the next reload (cnt == 0) or on entry to IDLE; pending_valid then clears.
  - A second config is stalled (cfg_ready = 0) until then.
- Transitions out of IDLE:
  - start = 1: go to RUN, cnt <= div_reg - 1, tick_cnt <= 0.
  - Otherwise single = 1: go to ONESHOT, cnt <= div_reg - 1.
  - start has priority over single.
- RUN:
  - cnt decrements each cycle.
  - At cnt == 0: reload div_reg - 1, or pending - 1 if pending_valid.
  - start is ignored.
  - stop = 1: go to IDLE next cycle. cnt <= 0; no tick in that next cycle. stop has priority over everything, including a coincident cnt == 0 (that tick still fires in the current cycle).
- ONESHOT:
  - At cnt == 0: tick fires, then go to IDLE.
  - stop aborts without a tick.
- tick = (state != IDLE) && cnt == 0.
  - Decoded from registers only; no input-to-output combinational path.
  - First tick occurs exactly div cycles after the cycle in which start was sampled. Example: start sampled at cycle N gives ticks at N+div, N+2div, and so on.
- phase = (state == RUN) && cnt < (div_reg >> 1).
  - Example div = 4: phase pattern 0,0,1,1. div = 5: 0,0,0,1,1.
  - phase is 0 in ONESHOT and IDLE.
- Ratio change takes effect starting with the period after the tick at which it is applied. There are no short or long periods.
- tick_cnt increments on each tick in RUN; wraps 255 -> 0.

Optional Feature:
- TICK_SCHED_CNT_EN
  - Defined: tick_cnt port and 8-bit counter are compiled in, with the behaviour above.
  - Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset low mid-run with div = 6 -> all outputs at reset values immediately; div_reg = DEFAULT_DIV after release.
- cfg_div = 4 in IDLE, then start pulse at cycle 10 -> tick at cycles 14, 18, 22; phase high in cycles 13-14, 17-18; busy = 1 from cycle 11.
- Running at div = 4, cfg_div = 7 accepted mid-period -> cfg_ready low until next tick; subsequent tick spacing 7; a second cfg held off until the switch.
- cfg_div = 0 then start -> ticks every 2 cycles; phase alternates 0,1.
- single with div = 5 at cycle 0 -> exactly one tick at cycle 5, busy falls at cycle 6; start and stop together in IDLE -> stays IDLE.
- stop asserted on the same cycle as cnt == 0 at div = 3 -> that tick fires, no further ticks; with TICK_SCHED_CNT_EN, 260 ticks -> tick_cnt = 4.

Source files
------------

// File: rtl/tick_sched.sv
// Programmable start/stop clock-enable scheduler: one-cycle tick plus phase square wave.
// Optional TICK_SCHED_CNT_EN adds the 8-bit tick_cnt output counting ticks since start.
module tick_sched #(
  parameter int unsigned CNT_W       = 17,
  parameter int unsigned DEFAULT_DIV = 100000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             start,
  input  logic             stop,
  input  logic             single,
  output logic             tick,
  output logic             phase,
  output logic             busy
`ifdef TICK_SCHED_CNT_EN
  ,
  output logic [7:0]       tick_cnt
`endif
);

  localparam int unsigned MIN_DIV = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    ONESHOT = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] div_reg, div_nxt;
  logic [CNT_W-1:0] pend_div, pend_div_nxt;
  logic             pend_valid, pend_valid_nxt;
  logic             tick_nxt, phase_nxt, busy_nxt, ready_nxt;
  logic             cfg_acc;
  logic             enter_idle;
  logic [CNT_W-1:0] cfg_clamped;
`ifdef TICK_SCHED_CNT_EN
  logic [7:0]       tick_cnt_nxt;
`endif

  // State, counters and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      div_reg    <= CNT_W'(DEFAULT_DIV);
      pend_div   <= '0;
      pend_valid <= 1'b0;
      tick       <= 1'b0;
      phase      <= 1'b0;
      busy       <= 1'b0;
      cfg_ready  <= 1'b1;
`ifdef TICK_SCHED_CNT_EN
      tick_cnt   <= 8'd0;
`endif
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      div_reg    <= div_nxt;
      pend_div   <= pend_div_nxt;
      pend_valid <= pend_valid_nxt;
      tick       <= tick_nxt;
      phase      <= phase_nxt;
      busy       <= busy_nxt;
      cfg_ready  <= ready_nxt;
`ifdef TICK_SCHED_CNT_EN
      tick_cnt   <= tick_cnt_nxt;
`endif
    end
  end

  // Next-state logic; outputs are decoded from the next register values so they
  // line up with the state they describe without any input-to-output path.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    div_nxt        = div_reg;
    pend_div_nxt   = pend_div;
    pend_valid_nxt = pend_valid;
    enter_idle     = 1'b0;
`ifdef TICK_SCHED_CNT_EN
    tick_cnt_nxt   = tick_cnt;
`endif
    cfg_acc     = cfg_valid && !pend_valid;
    cfg_clamped = (cfg_div < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : cfg_div;

    case (state)
      IDLE: begin
        if (cfg_acc) div_nxt = cfg_clamped;
        if (stop) begin
          state_nxt = IDLE;
        end else if (start) begin
          state_nxt = RUN;
          cnt_nxt   = div_nxt - CNT_W'(1);
`ifdef TICK_SCHED_CNT_EN
          tick_cnt_nxt = 8'd0;
`endif
        end else if (single) begin
          state_nxt = ONESHOT;
          cnt_nxt   = div_nxt - CNT_W'(1);
        end
      end
      RUN: begin
        if (cfg_acc) begin
          pend_div_nxt   = cfg_clamped;
          pend_valid_nxt = 1'b1;
        end
`ifdef TICK_SCHED_CNT_EN
        if (cnt == '0) tick_cnt_nxt = tick_cnt + 8'd1;
`endif
        if (stop) begin
          enter_idle = 1'b1;
        end else if (cnt == '0) begin
          // Period boundary: a pending ratio takes over for the next full period.
          if (pend_valid) begin
            div_nxt        = pend_div;
            cnt_nxt        = pend_div - CNT_W'(1);
            pend_valid_nxt = 1'b0;
          end else begin
            cnt_nxt = div_reg - CNT_W'(1);
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ONESHOT: begin
        if (cfg_acc) begin
          pend_div_nxt   = cfg_clamped;
          pend_valid_nxt = 1'b1;
        end
        if (stop || (cnt == '0)) begin
          enter_idle = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // Returning to IDLE applies whatever ratio is waiting, including one offered now.
    if (enter_idle) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      if (cfg_acc) begin
        div_nxt = cfg_clamped;
      end else if (pend_valid) begin
        div_nxt = pend_div;
      end
      pend_valid_nxt = 1'b0;
    end

    tick_nxt  = (state_nxt != IDLE) && (cnt_nxt == '0);
    phase_nxt = (state_nxt == RUN) && (cnt_nxt < (div_nxt >> 1));
    busy_nxt  = (state_nxt != IDLE);
    ready_nxt = !pend_valid_nxt;
  end

endmodule

// File: tb/tb_tick_sched.sv
// Scoreboard bench for tick_sched: expected tick cycles are queued by the stimulus,
// a negedge monitor pops them as ticks appear; level outputs are checked directly.
module tb_tick_sched;

  localparam int unsigned CNT_W   = 17;
  localparam int unsigned DEF_DIV = 10;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_div = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             single = 1'b0;
  logic             tick;
  logic             phase;
  logic             busy;
`ifdef TICK_SCHED_CNT_EN
  logic [7:0]       tick_cnt;
`endif

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int exp_q[$];

  tick_sched #(
    .CNT_W      (CNT_W),
    .DEFAULT_DIV(DEF_DIV)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_div  (cfg_div),
    .start    (start),
    .stop     (stop),
    .single   (single),
    .tick     (tick),
    .phase    (phase),
    .busy     (busy)
`ifdef TICK_SCHED_CNT_EN
    ,
    .tick_cnt (tick_cnt)
`endif
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Tick monitor: every tick must match the head of the expected queue.
  always @(negedge clock) begin : mon
    int e;
    if (tick === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_tick: tick at cycle %0d, none expected", cyc);
      end else begin
        e = exp_q.pop_front();
        if (e != cyc) begin
          failures++;
          $display("FAIL tick_time: tick at cycle %0d, expected cycle %0d", cyc, e);
        end
      end
    end else if (exp_q.size() > 0 && exp_q[0] <= cyc) begin
      checks++;
      failures++;
      e = exp_q.pop_front();
      $display("FAIL missed_tick: no tick by cycle %0d, expected cycle %0d", cyc, e);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) next_cycle();
  endtask

  task automatic sample_at(input int t);
    wait_cyc(t);
    @(negedge clock);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ticks(input int first, input int period, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(first + k * period);
  endtask

  // Offer a ratio in IDLE (accepted at the end of this cycle).
  task automatic cfg_idle(input int d);
    cfg_valid = 1'b1;
    cfg_div   = CNT_W'(d);
    next_cycle();
    cfg_valid = 1'b0;
  endtask

  task automatic stop_at(input int t);
    wait_cyc(t);
    stop = 1'b1;
    next_cycle();
    stop = 1'b0;
  endtask

  initial begin
    int c;
    // Reset values
    next_cycle();
    next_cycle();
    @(negedge clock);
    check("rst_tick", int'(tick), 0);
    check("rst_phase", int'(phase), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_cfg_ready", int'(cfg_ready), 1);
`ifdef TICK_SCHED_CNT_EN
    check("rst_tick_cnt", int'(tick_cnt), 0);
`endif
    reset = 1'b1;
    next_cycle();

    // div 4 from IDLE, continuous run
    cfg_idle(4);
    c = cyc;
    start = 1'b1;
    push_ticks(c + 4, 4, 3);
    sample_at(c);
    check("a_busy_before", int'(busy), 0);
    next_cycle();
    start = 1'b0;
    @(negedge clock);
    check("a_busy_run", int'(busy), 1);
    sample_at(c + 2);
    check("a_phase_c2", int'(phase), 0);
    sample_at(c + 3);
    check("a_phase_c3", int'(phase), 1);
    sample_at(c + 4);
    check("a_phase_c4", int'(phase), 1);
    sample_at(c + 5);
    check("a_phase_c5", int'(phase), 0);
    stop_at(c + 12);
    sample_at(c + 14);
    check("a_busy_stopped", int'(busy), 0);

    // Ratio change 4 -> 7 mid-period, second offer 5 stalled until the switch
    next_cycle();
    c = cyc;
    start = 1'b1;
    exp_q.push_back(c + 4);
    exp_q.push_back(c + 8);
    exp_q.push_back(c + 15);
    exp_q.push_back(c + 20);
    exp_q.push_back(c + 25);
    next_cycle();
    start = 1'b0;
    wait_cyc(c + 5);
    cfg_valid = 1'b1;
    cfg_div   = CNT_W'(7);
    sample_at(c + 5);
    check("b_ready_free", int'(cfg_ready), 1);
    wait_cyc(c + 6);
    cfg_div = CNT_W'(5);
    sample_at(c + 6);
    check("b_ready_pending", int'(cfg_ready), 0);
    sample_at(c + 8);
    check("b_ready_at_tick", int'(cfg_ready), 0);
    sample_at(c + 9);
    check("b_ready_after_switch", int'(cfg_ready), 1);
    wait_cyc(c + 10);
    cfg_valid = 1'b0;
    sample_at(c + 10);
    check("b_ready_second", int'(cfg_ready), 0);
    sample_at(c + 12);
    check("b_phase_div7_lo", int'(phase), 0);
    sample_at(c + 13);
    check("b_phase_div7_hi", int'(phase), 1);
    sample_at(c + 15);
    check("b_ready_second_held", int'(cfg_ready), 0);
    sample_at(c + 16);
    check("b_ready_second_done", int'(cfg_ready), 1);
    stop_at(c + 25);

    // cfg_div 0 clamps to 2
    next_cycle();
    cfg_idle(0);
    c = cyc;
    start = 1'b1;
    push_ticks(c + 2, 2, 4);
    next_cycle();
    start = 1'b0;
    @(negedge clock);
    check("c_phase_c1", int'(phase), 0);
    sample_at(c + 2);
    check("c_phase_c2", int'(phase), 1);
    sample_at(c + 3);
    check("c_phase_c3", int'(phase), 0);
    sample_at(c + 4);
    check("c_phase_c4", int'(phase), 1);
    stop_at(c + 8);

    // Single shot at div 5; then start+stop together in IDLE
    next_cycle();
    cfg_idle(5);
    c = cyc;
    single = 1'b1;
    exp_q.push_back(c + 5);
    next_cycle();
    single = 1'b0;
    sample_at(c + 4);
    check("d_phase_oneshot", int'(phase), 0);
    check("d_busy_oneshot", int'(busy), 1);
    sample_at(c + 5);
    check("d_busy_at_tick", int'(busy), 1);
    sample_at(c + 6);
    check("d_busy_after", int'(busy), 0);
    wait_cyc(c + 8);
    start = 1'b1;
    stop  = 1'b1;
    next_cycle();
    start = 1'b0;
    stop  = 1'b0;
    @(negedge clock);
    check("d_start_stop_idle", int'(busy), 0);
    sample_at(c + 12);
    check("d_still_idle", int'(busy), 0);

    // Stop coincident with the tick at div 3
    next_cycle();
    cfg_idle(3);
    c = cyc;
    start = 1'b1;
    push_ticks(c + 3, 3, 3);
    next_cycle();
    start = 1'b0;
    stop_at(c + 9);
    sample_at(c + 11);
    check("e_busy_stopped", int'(busy), 0);
    wait_cyc(c + 20);

    // Reset mid-run with a pending ratio; DEFAULT_DIV back afterwards
    cfg_idle(6);
    c = cyc;
    start = 1'b1;
    exp_q.push_back(c + 6);
    next_cycle();
    start = 1'b0;
    wait_cyc(c + 9);
    cfg_valid = 1'b1;
    cfg_div   = CNT_W'(9);
    next_cycle();
    cfg_valid = 1'b0;
    @(negedge clock);
    check("f_phase_pre", int'(phase), 1);
    check("f_ready_pre", int'(cfg_ready), 0);
    next_cycle();
    #2;
    reset = 1'b0;
    #1;
    check("f_rst_tick", int'(tick), 0);
    check("f_rst_phase", int'(phase), 0);
    check("f_rst_busy", int'(busy), 0);
    check("f_rst_cfg_ready", int'(cfg_ready), 1);
    @(negedge clock);
    reset = 1'b1;
    next_cycle();
    c = cyc;
    start = 1'b1;
    push_ticks(c + DEF_DIV, DEF_DIV, 2);
    next_cycle();
    start = 1'b0;
    stop_at(c + 2 * DEF_DIV);
    wait_cyc(c + 2 * DEF_DIV + 6);

`ifdef TICK_SCHED_CNT_EN
    // 260 ticks wrap the counter to 4
    cfg_idle(0);
    c = cyc;
    start = 1'b1;
    push_ticks(c + 2, 2, 260);
    next_cycle();
    start = 1'b0;
    sample_at(c + 5);
    check("g_tick_cnt_early", int'(tick_cnt), 2);
    stop_at(c + 520);
    sample_at(c + 522);
    check("g_tick_cnt_wrap", int'(tick_cnt), 4);
`endif

    repeat (4) next_cycle();
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
